// File: rtl/div_row_scalar_if.sv
// Handshake and data bundle for the row-by-scalar divider.
// The bench holds the master end and the divider holds the slave end.
interface div_row_scalar_if;
  // start is sampled only while the divider is idle. busy is high from the
  // accepting edge until the result edge. done pulses for one cycle with
  // m_out/ovf/dz, and those outputs hold until the next completion.
  logic        start;
  logic [39:0] m_in;
  logic [7:0]  d;
  logic [39:0] m_out;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        dz;
  logic [1:0]  state_dbg;

  modport master (
    output start, m_in, d,
    input  m_out, busy, done, ovf, dz, state_dbg
  );

  modport slave (
    input  start, m_in, d,
    output m_out, busy, done, ovf, dz, state_dbg
  );
endinterface

// File: rtl/div_row_scalar.sv
// Divides five packed signed 8-bit elements by one signed 8-bit scalar.
// It uses a parallel 8-step restoring divider with saturation and a divide-by-zero flag.
module div_row_scalar (
  input  logic              clk,
  input  logic              rst_n,
  div_row_scalar_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nx;

  // mag starts as the dividend magnitude. It shifts out MSB-first while
  // quotient bits shift in at the LSB, so after 8 steps it holds the quotient magnitude.
  logic [4:0][7:0] mag;
  logic [4:0][8:0] rem;
  logic [4:0]      sgn;
  logic [7:0]      dmag;
  logic            dsgn;
  logic            dzero;
  logic [2:0]      cnt;

  logic [4:0][8:0] rem_sh;
  logic [4:0][8:0] rem_nx;
  logic [4:0]      take;
  logic [4:0][7:0] res;
  logic [4:0]      sat;
  logic [4:0][7:0] abs_in;
  logic [4:0]      sgn_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.start) state_nx = RUN;
      RUN:     if (cnt == 3'd0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign io.busy      = (state != IDLE);
  assign io.state_dbg = state;

  always_comb begin
    rem_sh = '0;
    rem_nx = '0;
    take   = '0;
    res    = '0;
    sat    = '0;
    abs_in = '0;
    sgn_in = '0;
    for (int i = 0; i < 5; i++) begin
      sgn_in[i] = io.m_in[8*i+7];
      abs_in[i] = sgn_in[i] ? 8'(~io.m_in[8*i +: 8] + 8'd1) : io.m_in[8*i +: 8];

      rem_sh[i] = {rem[i][7:0], mag[i][7]};
      take[i]   = (rem_sh[i] >= {1'b0, dmag});
      rem_nx[i] = take[i] ? 9'(rem_sh[i] - {1'b0, dmag}) : rem_sh[i];

      // A negative 128 is exactly -128. A positive 128 only comes from -128/-1.
      if (sgn[i] ^ dsgn) begin
        res[i] = 8'(~mag[i] + 8'd1);
      end else if (mag[i] == 8'd128) begin
        res[i] = 8'h7f;
        sat[i] = 1'b1;
      end else begin
        res[i] = mag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag      <= '0;
      rem      <= '0;
      sgn      <= '0;
      dmag     <= '0;
      dsgn     <= 1'b0;
      dzero    <= 1'b0;
      cnt      <= '0;
      io.m_out <= '0;
      io.ovf   <= 1'b0;
      io.dz    <= 1'b0;
      io.done  <= 1'b0;
    end else begin
      io.done <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            mag   <= abs_in;
            sgn   <= sgn_in;
            dmag  <= io.d[7] ? 8'(~io.d + 8'd1) : io.d;
            dsgn  <= io.d[7];
            dzero <= (io.d == 8'd0);
            rem   <= '0;
            cnt   <= 3'd7;
          end
        end
        RUN: begin
          for (int i = 0; i < 5; i++) begin
            rem[i] <= rem_nx[i];
            mag[i] <= {mag[i][6:0], take[i]};
          end
          cnt <= cnt - 3'd1;
        end
        FIN: begin
          io.m_out <= dzero ? 40'd0 : res;
          io.ovf   <= dzero ? 1'b0 : |sat;
          io.dz    <= dzero;
          io.done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_row_scalar.sv
// Directed bench for div_row_scalar. It uses hand-computed rows and checks
// latency, result values, flags, the ignored start, mid-operation reset and back-to-back operation.
module tb_div_row_scalar;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_row_scalar_if io ();

  div_row_scalar dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then counts edges until done is seen. lat stays -1 if done never appears.
  task automatic do_op(input logic [39:0] m, input logic [7:0] dv, output int lat);
    io.m_in  = m;
    io.d     = dv;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (io.done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int ndone;
  int first_done;
  int second_done;
  logic [39:0] first_out;
  logic [39:0] second_out;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    io.start = 1'b0;
    io.m_in  = '0;
    io.d     = '0;
    #22 rst_n = 1'b1;
    tick();

    chk("rst_m_out", io.m_out, 40'd0);
    chk("rst_busy",  40'(io.busy), 40'd0);
    chk("rst_done",  40'(io.done), 40'd0);
    chk("rst_ovf",   40'(io.ovf), 40'd0);
    chk("rst_dz",    40'(io.dz), 40'd0);

    // Test 1: mixed signs, truncation toward zero.
    do_op(40'h649C07F900, 8'd3, lat);
    chk("basic_lat",   40'(lat), 40'd9);
    chk("basic_m_out", io.m_out, 40'h21DF02FE00);
    chk("basic_ovf",   40'(io.ovf), 40'd0);
    chk("basic_dz",    40'(io.dz), 40'd0);
    tick();
    chk("basic_done_pulse", 40'(io.done), 40'd0);
    chk("basic_busy_after", 40'(io.busy), 40'd0);

    // Test 2: -128/-1 saturates.
    do_op(40'h807F0100FF, 8'hFF, lat);
    chk("sat_lat",   40'(lat), 40'd9);
    chk("sat_m_out", io.m_out, 40'h7F81FF0001);
    chk("sat_ovf",   40'(io.ovf), 40'd1);
    chk("sat_dz",    40'(io.dz), 40'd0);
    tick();

    // Test 3: reset between E4 and E5 clears the outputs and suppresses done.
    io.m_in  = 40'h0A0A0A0A0A;
    io.d     = 8'd5;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_m_out", io.m_out, 40'd0);
    chk("mrst_busy",  40'(io.busy), 40'd0);
    chk("mrst_done",  40'(io.done), 40'd0);
    chk("mrst_ovf",   40'(io.ovf), 40'd0);
    chk("mrst_dz",    40'(io.dz), 40'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (io.done) ndone++;
    end
    chk("mrst_no_done", 40'(ndone), 40'd0);
    do_op(40'h1E1E1E1E1E, 8'hFD, lat);
    chk("mrst_fresh_lat",   40'(lat), 40'd9);
    chk("mrst_fresh_m_out", io.m_out, 40'hF6F6F6F6F6);
    tick();

    // Test 4: divide by zero, then d = 1 passes the row through and clears dz.
    do_op(40'h1234567890, 8'd0, lat);
    chk("dz_lat",   40'(lat), 40'd9);
    chk("dz_m_out", io.m_out, 40'd0);
    chk("dz_flag",  40'(io.dz), 40'd1);
    chk("dz_ovf",   40'(io.ovf), 40'd0);
    tick();
    do_op(40'h807F0100FF, 8'd1, lat);
    chk("d1_lat",   40'(lat), 40'd9);
    chk("d1_m_out", io.m_out, 40'h807F0100FF);
    chk("d1_dz",    40'(io.dz), 40'd0);
    chk("d1_ovf",   40'(io.ovf), 40'd0);
    tick();

    // Test 5: a second start at E3 is ignored.
    io.m_in  = 40'h0A0A0A0A0A;
    io.d     = 8'd5;
    io.start = 1'b1;
    tick();
    io.start   = 1'b0;
    ndone      = 0;
    first_done = -1;
    first_out  = '0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        io.m_in  = 40'h7F7F7F7F7F;
        io.d     = 8'd1;
        io.start = 1'b1;
      end
      tick();
      if (k == 3) io.start = 1'b0;
      if (io.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          first_out  = io.m_out;
        end
      end
    end
    chk("busy_start_ndone", 40'(ndone), 40'd1);
    chk("busy_start_lat",   40'(first_done), 40'd9);
    chk("busy_start_m_out", first_out, 40'h0202020202);

    // Test 6: start is held high and the divisor is -128. The second operation is accepted at E10.
    io.m_in  = 40'h807F000180;
    io.d     = 8'h80;
    io.start = 1'b1;
    tick();
    io.m_in     = 40'h649C07F900;
    io.d        = 8'd3;
    first_done  = -1;
    second_done = -1;
    first_out   = '0;
    second_out  = '0;
    ndone       = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 10) begin
        io.start = 1'b0;
        chk("b2b_busy_e10", 40'(io.busy), 40'd1);
      end
      if (io.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          first_out  = io.m_out;
        end else if (second_done < 0) begin
          second_done = k;
          second_out  = io.m_out;
        end
      end
    end
    chk("b2b_first_lat",    40'(first_done), 40'd9);
    chk("b2b_first_m_out",  first_out, 40'h0100000001);
    chk("b2b_second_lat",   40'(second_done), 40'd19);
    chk("b2b_second_m_out", second_out, 40'h21DF02FE00);
    chk("b2b_ndone",        40'(ndone), 40'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_row_scalar.md
# div_row_scalar

Sequential scalar divider for the matrix coprocessor. It takes one packed matrix row of five signed 8-bit elements and divides every element by a signed 8-bit scalar. It is the inverse-direction companion of the row-by-scalar multiplier and uses the same row packing. All five elements run in parallel through an 8-iteration restoring divider, with a start/done handshake, saturation on overflow and a divide-by-zero flag.

## Interface
Parameters: none. Widths are fixed by the coprocessor row format: 5 elements × 8 bits = 40 bits.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- m_in  in  40  signed row; element 4 = [39:32] … element 0 = [7:0]; two's complement
- d  in  8  signed scalar divisor
- m_out  out  40  signed quotient row, same packing as m_in; held until the next completion
- busy  out  1  high while an operation is in flight (state ≠ IDLE)
- done  out  1  one-cycle pulse when m_out/ovf/dz have just been updated
- ovf  out  1  at least one element saturated in the last operation
- dz  out  1  last operation had d == 0

## Operation
- **States:** IDLE, RUN, FIN.
- **IDLE, start=1:**
  - Latch, per element, sign and 8-bit unsigned magnitude (|−128| = 128).
  - Latch the divisor magnitude and sign.
  - Clear the 9-bit partial remainders, set the iteration counter to 7, go to RUN.
- **RUN:**
  - One restoring step per cycle for all five elements.
  - Shift the remainder left and bring in the next dividend MSB.
  - Subtract the divisor magnitude if the result stays non-negative; the quotient bit is 1 if the subtraction was taken.
  - After the step with counter = 0, go to FIN (8 RUN cycles total).
- **FIN:**
  - Apply sign: negate the quotient magnitude if element sign XOR divisor sign.
  - Positive magnitude 128 (only −128 / −1) saturates to +127 and sets ovf.
  - Negative magnitude 128 gives −128 with no overflow.
  - Register m_out, ovf and dz; pulse done; go to IDLE.
- **Rounding:** truncation toward zero (−7/2 = −3). No remainder is output.
- **d == 0:**
  - Same state sequence and latency.
  - m_out = 0, dz = 1, ovf = 0.
- **start when not IDLE:** ignored, including in FIN. Operands are never re-sampled mid-operation.
- **Reset:** an rst_n low at any time, including mid-operation, forces IDLE.
  - m_out = 0, busy = 0, done = 0, ovf = 0, dz = 0; counter and remainders are cleared.
  - No done is produced for the aborted operation.

## Timing
- Edge E0 accepts start; busy is high from E0 to E9.
- E1–E8 perform the RUN iterations; E9 is the FIN update.
- done is high for exactly the cycle between E9 and E10, together with the new m_out, ovf and dz.
- Latency from start acceptance to done is 9 cycles; throughput is one row per 10 cycles.
- A start held high at E10 is accepted, giving back-to-back operation.
- m_in and d may change after E0 without effect.
- ovf and dz are not sticky across operations; each completion overwrites them.

## Test plan
- **Basic mixed signs:** m_in = 0x649C07F900 (100, −100, 7, −7, 0), d = 3, pulse start.
  - done exactly 9 cycles later; m_out = 0x21DF02FE00 (33, −33, 2, −2, 0); ovf = 0, dz = 0.
- **Saturation:** m_in = 0x807F0100FF (−128, 127, 1, 0, −1), d = 0xFF (−1).
  - m_out = 0x7F81FF0001; ovf = 1.
- **Divide by zero:** d = 0 with any row.
  - m_out = 0x0000000000, dz = 1, done still at 9 cycles.
  - The next operation with d = 1 clears dz and returns m_in unchanged.
- **Start while busy:** start with (0x0A0A0A0A0A, d = 5), then start again at E3 with different operands.
  - Only one done; m_out = 0x0202020202.
- **Reset mid-operation:** drive rst_n low between E4 and E5.
  - All outputs are 0 immediately; no done follows.
  - A fresh start after release completes normally.
- **Back-to-back and divisor −128:** hold start high; first op m_in = 0x807F000180, d = 0x80; second op accepted at E10.
  - First m_out = 0x0100000001; second done at E19.
